io_bus_arbiter: RTL and testbench

// - Shares the 8-bit memory-mapped register bus of the GPIO/counter-timer io block between two masters:
//   m0 (CPU) and m1 (auxiliary sequencer/DMA).
// - Accepts one request at a time and drives single-cycle w_en/r_en strobes toward the io block.
// - Returns the io block's registered read data to the owning master.
// - Sits between the masters and the io block's din/address/w_en/r_en/dout port.

---
 rtl/io_bus_arbiter_if.sv | 21 ++
 rtl/io_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Per-master channel of the io register bus arbiter: request/write side from the
// master, grant/read-return side from the arbiter. One instance per master.
interface io_bus_arbiter_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       gnt;
    logic       rvalid;
    logic [7:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the GPIO/counter-timer io register bus: one transaction at
// a time, single-cycle w_en/r_en strobes, registered read data routed to its owner.
module io_bus_arbiter #(
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    io_bus_arbiter_if.slave       m0,
    io_bus_arbiter_if.slave       m1,
    output logic [7:0]            s_address,
    output logic [7:0]            s_din,
    output logic                  s_w_en,
    output logic                  s_r_en,
    input  logic [7:0]            s_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    // WAIT lasts READ_LATENCY cycles; the counter runs down to zero.
    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    state_e     state_q;
    logic       last_grant_q;
    logic       owner_q;
    logic [7:0] addr_q;
    logic [7:0] din_q;
    logic       w_en_q;
    logic       r_en_q;
    logic [2:0] cnt_q;
    logic [1:0] gnt_q;
    logic [1:0] rvalid_q;
    logic [7:0] rdata0_q;
    logic [7:0] rdata1_q;

    logic       any_req_d;
    logic       grant_d;
    logic       win_we_d;
    logic [7:0] win_addr_d;
    logic [7:0] win_wdata_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        any_req_d   = m0.req | m1.req;
        grant_d     = 1'b0;
        if (m0.req && m1.req) begin
            grant_d = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else if (m1.req) begin
            grant_d = 1'b1;
        end
        win_we_d    = grant_d ? m1.we    : m0.we;
        win_addr_d  = grant_d ? m1.addr  : m0.addr;
        win_wdata_d = grant_d ? m1.wdata : m0.wdata;
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            w_en_q       <= 1'b0;
            r_en_q       <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= win_addr_d;
                        if (win_we_d) begin
                            din_q <= win_wdata_d;
                        end
                        gnt_q        <= grant_d ? 2'b10 : 2'b01;
                        w_en_q       <= win_we_d;
                        r_en_q       <= ~win_we_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // w_en_q still holds this transaction's direction here.
                    if (w_en_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= WAIT_LAST;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (owner_q) begin
                            rdata1_q <= s_dout;
                            rvalid_q <= 2'b10;
                        end else begin
                            rdata0_q <= s_dout;
                            rvalid_q <= 2'b01;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0.gnt    = gnt_q[0];
    assign m1.gnt    = gnt_q[1];
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;

    assign s_address = addr_q;
    assign s_din     = din_q;
    assign s_w_en    = w_en_q;
    assign s_r_en    = r_en_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: three instances cover round-robin, fixed
// priority and a 3-cycle read latency; read data is checked through a scoreboard.
module tb_io_bus_arbiter;

    typedef struct packed {
        logic       m;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_bus_arbiter_if rr0 ();
    io_bus_arbiter_if rr1 ();
    io_bus_arbiter_if fp0 ();
    io_bus_arbiter_if fp1 ();
    io_bus_arbiter_if l30 ();
    io_bus_arbiter_if l31 ();

    logic [7:0] rr_addr, rr_din, rr_dout, rr_drv;
    logic       rr_wen, rr_ren, rr_busy, rr_model;
    logic [7:0] fp_addr, fp_din, fp_dout;
    logic       fp_wen, fp_ren, fp_busy;
    logic [7:0] l3_addr, l3_din, l3_dout, l3_drv;
    logic       l3_wen, l3_ren, l3_busy;

    // Slave models: fixed function of the presented address, or a directly driven value.
    assign rr_dout = rr_model ? (rr_addr ^ 8'h5A) : rr_drv;
    assign fp_dout = fp_addr ^ 8'h5A;
    assign l3_dout = l3_drv;

    io_bus_arbiter #(.READ_LATENCY(1), .FIXED_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rst(rst), .m0(rr0), .m1(rr1),
        .s_address(rr_addr), .s_din(rr_din), .s_w_en(rr_wen), .s_r_en(rr_ren),
        .s_dout(rr_dout), .busy(rr_busy)
    );

    io_bus_arbiter #(.READ_LATENCY(1), .FIXED_PRIORITY(1'b1)) u_fp (
        .clk(clk), .rst(rst), .m0(fp0), .m1(fp1),
        .s_address(fp_addr), .s_din(fp_din), .s_w_en(fp_wen), .s_r_en(fp_ren),
        .s_dout(fp_dout), .busy(fp_busy)
    );

    io_bus_arbiter #(.READ_LATENCY(3), .FIXED_PRIORITY(1'b0)) u_l3 (
        .clk(clk), .rst(rst), .m0(l30), .m1(l31),
        .s_address(l3_addr), .s_din(l3_din), .s_w_en(l3_wen), .s_r_en(l3_ren),
        .s_dout(l3_dout), .busy(l3_busy)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic exp_m;
    int   ngnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic m, input logic [7:0] rdata);
        exp_t e;
        check({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_owner"}, 32'(m), 32'(e.m));
            check({tag, "_rdata"}, 32'(rdata), 32'(e.d));
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rr_model = 1'b0;
        rr_drv = 8'h00;
        l3_drv = 8'h00;
        rr0.req = 1'b0; rr0.we = 1'b0; rr0.addr = 8'h00; rr0.wdata = 8'h00;
        rr1.req = 1'b0; rr1.we = 1'b0; rr1.addr = 8'h00; rr1.wdata = 8'h00;
        fp0.req = 1'b0; fp0.we = 1'b0; fp0.addr = 8'h00; fp0.wdata = 8'h00;
        fp1.req = 1'b0; fp1.we = 1'b0; fp1.addr = 8'h00; fp1.wdata = 8'h00;
        l30.req = 1'b0; l30.we = 1'b0; l30.addr = 8'h00; l30.wdata = 8'h00;
        l31.req = 1'b0; l31.we = 1'b0; l31.addr = 8'h00; l31.wdata = 8'h00;

        // Reset state
        step(); step();
        check("rst_gnt",    32'({rr0.gnt, rr1.gnt}), 32'd0);
        check("rst_rvalid", 32'({rr0.rvalid, rr1.rvalid}), 32'd0);
        check("rst_strobe", 32'({rr_wen, rr_ren}), 32'd0);
        check("rst_busy",   32'(rr_busy), 32'd0);
        check("rst_addr",   32'(rr_addr), 32'd0);
        check("rst_rdata",  32'({rr0.rdata, rr1.rdata}), 32'd0);
        rst = 1'b0;

        // m0 write 0xA5 to 0x01
        rr0.req = 1'b1; rr0.we = 1'b1; rr0.addr = 8'h01; rr0.wdata = 8'hA5;
        step();
        check("wr_gnt0",  32'(rr0.gnt), 32'd1);
        check("wr_gnt1",  32'(rr1.gnt), 32'd0);
        check("wr_wen",   32'(rr_wen), 32'd1);
        check("wr_ren",   32'(rr_ren), 32'd0);
        check("wr_addr",  32'(rr_addr), 32'h01);
        check("wr_din",   32'(rr_din), 32'hA5);
        check("wr_busy",  32'(rr_busy), 32'd1);
        rr0.req = 1'b0; rr0.we = 1'b0; rr0.addr = 8'hFF; rr0.wdata = 8'h00;
        step();
        check("wr_wen_1cyc", 32'({rr_wen, rr_ren}), 32'd0);
        check("wr_idle",     32'(rr_busy), 32'd0);
        check("wr_addr_hold", 32'(rr_addr), 32'h01);
        check("wr_din_hold",  32'(rr_din), 32'hA5);

        // m1 read from 0x02; s_dout carries 0x3C only during T+2
        rr1.req = 1'b1; rr1.we = 1'b0; rr1.addr = 8'h02;
        rr_drv = 8'hFF;
        sb.push_back('{1'b1, 8'h3C});
        step();
        check("rd_gnt1", 32'(rr1.gnt), 32'd1);
        check("rd_gnt0", 32'(rr0.gnt), 32'd0);
        check("rd_ren",  32'(rr_ren), 32'd1);
        check("rd_wen",  32'(rr_wen), 32'd0);
        check("rd_addr", 32'(rr_addr), 32'h02);
        rr1.req = 1'b0;
        @(posedge clk); #1 rr_drv = 8'h3C;
        @(negedge clk);
        check("rd_no_early_rvalid", 32'(rr1.rvalid), 32'd0);
        check("rd_ren_1cyc", 32'(rr_ren), 32'd0);
        @(posedge clk); #1 rr_drv = 8'hEE;
        @(negedge clk);
        check("rd_rvalid1", 32'(rr1.rvalid), 32'd1);
        if (rr1.rvalid) sb_pop("rd_m1", 1'b1, rr1.rdata);
        check("rd_rvalid0", 32'(rr0.rvalid), 32'd0);
        check("rd_m0_rdata_kept", 32'(rr0.rdata), 32'h00);
        step();
        check("rd_rvalid_1cyc", 32'(rr1.rvalid), 32'd0);
        check("rd_rdata_hold",  32'(rr1.rdata), 32'h3C);

        // Round-robin contention, straight after reset
        rst = 1'b1; step(); rst = 1'b0;
        rr_model = 1'b1;
        rr0.req = 1'b1; rr0.we = 1'b0; rr0.addr = 8'h10;
        rr1.req = 1'b1; rr1.we = 1'b0; rr1.addr = 8'h20;
        exp_m = 1'b0; ngnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("rr_strobe_excl", 32'(rr_wen & rr_ren), 32'd0);
            if (rr0.gnt || rr1.gnt) begin
                check("rr_gnt_owner",  32'(rr1.gnt), 32'(exp_m));
                check("rr_gnt_single", 32'(rr0.gnt & rr1.gnt), 32'd0);
                sb.push_back('{exp_m, (exp_m ? 8'h20 : 8'h10) ^ 8'h5A});
                exp_m = ~exp_m;
                ngnt++;
            end
            if (rr0.rvalid) sb_pop("rr_rd_m0", 1'b0, rr0.rdata);
            if (rr1.rvalid) sb_pop("rr_rd_m1", 1'b1, rr1.rdata);
        end
        rr0.req = 1'b0; rr1.req = 1'b0;
        check("rr_grant_count", 32'(ngnt), 32'd4);
        step(); step();
        check("rr_idle_after", 32'(rr_busy), 32'd0);
        check("rr_sb_drained", 32'(sb.size()), 32'd0);

        // Fixed priority: m0 holds the bus until it drops its request
        fp0.req = 1'b1; fp0.we = 1'b0; fp0.addr = 8'h40;
        fp1.req = 1'b1; fp1.we = 1'b0; fp1.addr = 8'h50;
        ngnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("fp_strobe_excl", 32'(fp_wen & fp_ren), 32'd0);
            if (fp0.gnt || fp1.gnt) begin
                exp_m = (ngnt >= 3);
                check("fp_gnt_owner",  32'(fp1.gnt), 32'(exp_m));
                check("fp_gnt_single", 32'(fp0.gnt & fp1.gnt), 32'd0);
                sb.push_back('{exp_m, (exp_m ? 8'h50 : 8'h40) ^ 8'h5A});
                if (ngnt == 2) fp0.req = 1'b0;
                if (ngnt == 3) fp1.req = 1'b0;
                ngnt++;
            end
            if (fp0.rvalid) sb_pop("fp_rd_m0", 1'b0, fp0.rdata);
            if (fp1.rvalid) sb_pop("fp_rd_m1", 1'b1, fp1.rdata);
        end
        check("fp_grant_count", 32'(ngnt), 32'd4);
        check("fp_sb_drained", 32'(sb.size()), 32'd0);

        // Reset during WAIT of an m1 read aborts it
        rr1.req = 1'b1; rr1.we = 1'b0; rr1.addr = 8'h66;
        step();
        check("ab_gnt1", 32'(rr1.gnt), 32'd1);
        rr1.req = 1'b0;
        step();
        check("ab_busy_wait", 32'(rr_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("ab_ren",    32'(rr_ren), 32'd0);
        check("ab_busy",   32'(rr_busy), 32'd0);
        check("ab_rvalid", 32'({rr0.rvalid, rr1.rvalid}), 32'd0);
        check("ab_rdata",  32'(rr1.rdata), 32'd0);
        step();
        check("ab_no_rvalid", 32'({rr0.rvalid, rr1.rvalid}), 32'd0);
        rst = 1'b0;
        rr0.req = 1'b1; rr0.we = 1'b0; rr0.addr = 8'h10;
        rr1.req = 1'b1; rr1.we = 1'b0; rr1.addr = 8'h20;
        step();
        check("ab_first_gnt0", 32'(rr0.gnt), 32'd1);
        check("ab_first_gnt1", 32'(rr1.gnt), 32'd0);
        sb.push_back('{1'b0, 8'h10 ^ 8'h5A});
        rr0.req = 1'b0; rr1.req = 1'b0;
        step(); step();
        check("ab_rvalid0", 32'(rr0.rvalid), 32'd1);
        check("ab_rvalid1", 32'(rr1.rvalid), 32'd0);
        if (rr0.rvalid) sb_pop("ab_rd_m0", 1'b0, rr0.rdata);

        // READ_LATENCY=3: s_dout valid only in T+4
        l30.req = 1'b1; l30.we = 1'b0; l30.addr = 8'h30;
        l3_drv = 8'h11;
        sb.push_back('{1'b0, 8'h77});
        step();
        check("l3_gnt0", 32'(l30.gnt), 32'd1);
        check("l3_ren",  32'(l3_ren), 32'd1);
        check("l3_busy_t1", 32'(l3_busy), 32'd1);
        l30.req = 1'b0;
        step();
        check("l3_busy_t2",   32'(l3_busy), 32'd1);
        check("l3_ren_1cyc",  32'(l3_ren), 32'd0);
        check("l3_rvalid_t2", 32'(l30.rvalid), 32'd0);
        step();
        check("l3_busy_t3",   32'(l3_busy), 32'd1);
        check("l3_rvalid_t3", 32'(l30.rvalid), 32'd0);
        @(posedge clk); #1 l3_drv = 8'h77;
        @(negedge clk);
        check("l3_busy_t4",   32'(l3_busy), 32'd1);
        check("l3_rvalid_t4", 32'(l30.rvalid), 32'd0);
        @(posedge clk); #1 l3_drv = 8'h22;
        @(negedge clk);
        check("l3_busy_t5",   32'(l3_busy), 32'd0);
        check("l3_rvalid_t5", 32'(l30.rvalid), 32'd1);
        if (l30.rvalid) sb_pop("l3_rd_m0", 1'b0, l30.rdata);
        step();
        check("l3_rvalid_1cyc", 32'(l30.rvalid), 32'd0);
        check("l3_rdata_hold",  32'(l30.rdata), 32'h77);
        check("l3_sb_drained",  32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
